// File: rtl/fpu_div_arbiter.sv
// Two-port arbiter in front of a single shared FP divider with a strobe/ack operand interface.
// Only one division is in flight at a time; grant is round-robin or fixed priority via RR_EN.
module fpu_div_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_r0_valid,
   input  logic [31:0] i_r0_a,
   input  logic [31:0] i_r0_b,
   input  logic        i_r1_valid,
   input  logic [31:0] i_r1_a,
   input  logic [31:0] i_r1_b,
   output logic        o_r0_ready,
   output logic        o_r1_ready,
   output logic        o_r0_resp_valid,
   output logic        o_r1_resp_valid,
   input  logic        i_r0_resp_ready,
   input  logic        i_r1_resp_ready,
   output logic [31:0] o_resp_z,
   output logic [31:0] o_div_a,
   output logic [31:0] o_div_b,
   output logic        o_div_a_stb,
   output logic        o_div_b_stb,
   input  logic        i_div_a_ack,
   input  logic        i_div_b_ack,
   input  logic [31:0] i_div_z,
   input  logic        i_div_z_stb,
   output logic        o_div_z_ack,
   output logic [7:0]  o_div_cycles
);

   // state  | meaning
   // IDLE   | waiting for a requester; grant and latch operands
   // SEND_A | presenting dividend to the divider
   // SEND_B | presenting divisor to the divider
   // WAIT_Z | waiting for the quotient strobe
   // RESP   | holding the quotient for the granted requester
   typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

   state_t      r_state;
   logic        r_gnt;
   logic        r_last_grant;
   logic [31:0] r_div_a;
   logic [31:0] r_div_b;
   logic        r_a_stb;
   logic        r_b_stb;
   logic        r_z_ack;
   logic [31:0] r_resp_z;
   logic        r_r0_ready;
   logic        r_r1_ready;
   logic        r_r0_rv;
   logic        r_r1_rv;
   logic [7:0]  r_cnt;
   logic [7:0]  r_div_cycles;

   logic        w_any;
   logic        w_win;
   logic        w_resp_rdy;
   logic [7:0]  w_cnt_inc;

   assign w_any      = i_r0_valid | i_r1_valid;
   assign w_resp_rdy = r_gnt ? i_r1_resp_ready : i_r0_resp_ready;
   assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

   // A lone requester always wins; ties go to the port not granted last in RR mode.
   always_comb begin
      w_win = 1'b0;
      if (i_r0_valid && i_r1_valid)
         w_win = (RR_EN != 0) ? ~r_last_grant : 1'b0;
      else if (!i_r0_valid)
         w_win = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_gnt        <= 1'b0;
         r_last_grant <= 1'b1;
         r_div_a      <= '0;
         r_div_b      <= '0;
         r_a_stb      <= 1'b0;
         r_b_stb      <= 1'b0;
         r_z_ack      <= 1'b0;
         r_resp_z     <= '0;
         r_r0_ready   <= 1'b0;
         r_r1_ready   <= 1'b0;
         r_r0_rv      <= 1'b0;
         r_r1_rv      <= 1'b0;
         r_cnt        <= '0;
         r_div_cycles <= '0;
      end else begin
         r_r0_ready <= 1'b0;
         r_r1_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt      <= w_win;
                  r_div_a    <= w_win ? i_r1_a : i_r0_a;
                  r_div_b    <= w_win ? i_r1_b : i_r0_b;
                  r_r0_ready <= ~w_win;
                  r_r1_ready <= w_win;
                  r_a_stb    <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= SEND_A;
               end
            end
            SEND_A: begin
               r_cnt <= w_cnt_inc;
               if (r_a_stb && i_div_a_ack) begin
                  r_a_stb <= 1'b0;
                  r_b_stb <= 1'b1;
                  r_state <= SEND_B;
               end
            end
            SEND_B: begin
               r_cnt <= w_cnt_inc;
               if (r_b_stb && i_div_b_ack) begin
                  r_b_stb <= 1'b0;
                  r_z_ack <= 1'b1;
                  r_state <= WAIT_Z;
               end
            end
            WAIT_Z: begin
               r_cnt <= w_cnt_inc;
               // latency includes the capture cycle itself
               if (r_z_ack && i_div_z_stb) begin
                  r_z_ack      <= 1'b0;
                  r_resp_z     <= i_div_z;
                  r_div_cycles <= w_cnt_inc;
                  r_r0_rv      <= ~r_gnt;
                  r_r1_rv      <= r_gnt;
                  r_state      <= RESP;
               end
            end
            RESP: begin
               if (w_resp_rdy) begin
                  r_r0_rv      <= 1'b0;
                  r_r1_rv      <= 1'b0;
                  r_last_grant <= r_gnt;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_r0_ready      = r_r0_ready;
   assign o_r1_ready      = r_r1_ready;
   assign o_r0_resp_valid = r_r0_rv;
   assign o_r1_resp_valid = r_r1_rv;
   assign o_resp_z        = r_resp_z;
   assign o_div_a         = r_div_a;
   assign o_div_b         = r_div_b;
   assign o_div_a_stb     = r_a_stb;
   assign o_div_b_stb     = r_b_stb;
   assign o_div_z_ack     = r_z_ack;
   assign o_div_cycles    = r_div_cycles;

endmodule

// File: tb/tb_fpu_div_arbiter.sv
// Bench for fpu_div_arbiter: two instances (round-robin and fixed priority), each with a
// behavioural divider; a scoreboard predicts grant order and quotients.
module tb_fpu_div_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [1:0]       v0, v1, rdy0, rdy1, rv0, rv1, rr0, rr1;
   logic [1:0]       astb, bstb, aack, back, zstb, zack;
   logic [1:0][31:0] a0, b0, a1, b1, rz, da, db, dz;
   logic [1:0][7:0]  dcyc;

   fpu_div_arbiter #(.RR_EN(1)) u_rr (
      .clk(clk), .rst(rst),
      .i_r0_valid(v0[0]), .i_r0_a(a0[0]), .i_r0_b(b0[0]),
      .i_r1_valid(v1[0]), .i_r1_a(a1[0]), .i_r1_b(b1[0]),
      .o_r0_ready(rdy0[0]), .o_r1_ready(rdy1[0]),
      .o_r0_resp_valid(rv0[0]), .o_r1_resp_valid(rv1[0]),
      .i_r0_resp_ready(rr0[0]), .i_r1_resp_ready(rr1[0]),
      .o_resp_z(rz[0]), .o_div_a(da[0]), .o_div_b(db[0]),
      .o_div_a_stb(astb[0]), .o_div_b_stb(bstb[0]),
      .i_div_a_ack(aack[0]), .i_div_b_ack(back[0]),
      .i_div_z(dz[0]), .i_div_z_stb(zstb[0]), .o_div_z_ack(zack[0]),
      .o_div_cycles(dcyc[0]));

   fpu_div_arbiter #(.RR_EN(0)) u_fp (
      .clk(clk), .rst(rst),
      .i_r0_valid(v0[1]), .i_r0_a(a0[1]), .i_r0_b(b0[1]),
      .i_r1_valid(v1[1]), .i_r1_a(a1[1]), .i_r1_b(b1[1]),
      .o_r0_ready(rdy0[1]), .o_r1_ready(rdy1[1]),
      .o_r0_resp_valid(rv0[1]), .o_r1_resp_valid(rv1[1]),
      .i_r0_resp_ready(rr0[1]), .i_r1_resp_ready(rr1[1]),
      .o_resp_z(rz[1]), .o_div_a(da[1]), .o_div_b(db[1]),
      .o_div_a_stb(astb[1]), .o_div_b_stb(bstb[1]),
      .i_div_a_ack(aack[1]), .i_div_b_ack(back[1]),
      .i_div_z(dz[1]), .i_div_z_stb(zstb[1]), .o_div_z_ack(zack[1]),
      .o_div_cycles(dcyc[1]));

   typedef struct {int port; logic [31:0] z;} resp_t;

   int          checks = 0;
   int          errors = 0;
   int          exp_gnt [2][$];
   resp_t       exp_rsp [2][$];
   int          glog    [2][$];
   logic [31:0] last_z  [2];
   int          done_cnt[2];
   int          model_last[2];
   int          dlat[2];

   function automatic real sp2r(logic [31:0] x);
      logic [63:0] d;
      d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(real r);
      logic [63:0] d;
      int          e;
      d = $realtobits(r);
      e = int'(d[62:52]) - 896;
      if (e >= 255) return {d[63], 8'hFF, 23'd0};
      if (e <= 0) return {d[63], 31'd0};
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // Reference quotient, truncated; operands are normal numbers or zero in this bench.
   function automatic logic [31:0] ref_div(logic [31:0] a, logic [31:0] b);
      logic s;
      s = a[31] ^ b[31];
      if (b[30:23] == 8'd0) return (a[30:23] == 8'd0) ? 32'h7FC00000 : {s, 8'hFF, 23'd0};
      if (a[30:23] == 8'd0) return {s, 31'd0};
      return r2sp(sp2r(a) / sp2r(b));
   endfunction

   function automatic logic [31:0] rnd_fp();
      return {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
   endfunction

   task automatic expect_eq(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Divider model: random operand acks, programmable latency, garbage on z while not strobing.
   initial begin : divider
      logic [1:0]  hsa, hsb, hsz;
      logic        rs;
      logic [31:0] sa [2];
      logic [31:0] sb [2];
      logic [31:0] opa [2];
      logic [31:0] opb [2];
      int          left [2];
      bit          busy [2];
      aack = '0; back = '0; zstb = '0; dz = '0;
      for (int i = 0; i < 2; i++) begin busy[i] = 0; left[i] = 0; opa[i] = '0; opb[i] = '0; end
      forever begin
         @(negedge clk);
         rs = rst;
         for (int i = 0; i < 2; i++) begin
            hsa[i] = astb[i] & aack[i];
            hsb[i] = bstb[i] & back[i];
            hsz[i] = zstb[i] & zack[i];
            sa[i]  = da[i];
            sb[i]  = db[i];
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (rs) begin
               aack[i] = 0; back[i] = 0; zstb[i] = 0; dz[i] = '0; busy[i] = 0;
            end else begin
               aack[i] = 1'($urandom);
               back[i] = 1'($urandom);
               if (hsa[i]) opa[i] = sa[i];
               if (hsb[i]) begin opb[i] = sb[i]; busy[i] = 1; left[i] = dlat[i]; end
               if (hsz[i]) zstb[i] = 0;
               if (busy[i]) begin
                  if (left[i] <= 1) begin
                     zstb[i] = 1; dz[i] = ref_div(opa[i], opb[i]); busy[i] = 0;
                  end else left[i]--;
               end else if (!zstb[i]) dz[i] = $urandom;
            end
         end
      end
   end

   // Monitor: grant pulses, response handshakes and latency, checked against the scoreboard.
   initial begin : monitor
      int    p;
      resp_t r;
      int    act [2];
      int    cyc [2];
      int    pend [2];
      int    exp_dc [2];
      for (int i = 0; i < 2; i++) begin act[i] = 0; cyc[i] = 0; pend[i] = 0; exp_dc[i] = 0; end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rst) begin
               act[i] = 0; pend[i] = 0;
            end else begin
               if (pend[i] != 0) begin
                  expect_eq("div_cycles", 64'(dcyc[i]), 64'(exp_dc[i]));
                  pend[i] = 0;
               end
               if (rdy0[i] || rdy1[i]) begin
                  p = rdy1[i] ? 1 : 0;
                  if (rdy0[i] && rdy1[i]) expect_eq("both_ready", 64'(rdy0[i] & rdy1[i]), 64'd0);
                  else if (exp_gnt[i].size() == 0) expect_eq("unexpected_grant", 64'(p), 64'hDEAD);
                  else expect_eq($sformatf("grant_port_i%0d", i), 64'(p), 64'(exp_gnt[i].pop_front()));
                  glog[i].push_back(p);
                  act[i] = 1; cyc[i] = 1;
               end else if (act[i] != 0) cyc[i]++;
               if (zstb[i] && zack[i] && act[i] != 0) begin
                  exp_dc[i] = (cyc[i] > 255) ? 255 : cyc[i];
                  pend[i] = 1; act[i] = 0;
               end
               if ((rv0[i] && rr0[i]) || (rv1[i] && rr1[i])) begin
                  p = (rv1[i] && rr1[i]) ? 1 : 0;
                  if (rv0[i] && rv1[i]) expect_eq("both_resp_valid", 64'(rv0[i] & rv1[i]), 64'd0);
                  else if (exp_rsp[i].size() == 0) expect_eq("unexpected_resp", 64'(rz[i]), 64'hDEAD);
                  else begin
                     r = exp_rsp[i].pop_front();
                     expect_eq($sformatf("resp_port_i%0d", i), 64'(p), 64'(r.port));
                     expect_eq($sformatf("resp_z_i%0d", i), 64'(rz[i]), 64'(r.z));
                  end
                  last_z[i] = rz[i];
                  done_cnt[i]++;
               end
            end
         end
      end
   end

   task automatic check_reset_outs(int i);
      expect_eq($sformatf("reset_outs_i%0d", i),
                64'({rdy0[i], rdy1[i], rv0[i], rv1[i], astb[i], bstb[i], zack[i]}) |
                64'(rz[i]) | 64'(da[i]) | 64'(db[i]) | 64'(dcyc[i]), 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1; v0 = '0; v1 = '0; rr0 = '0; rr1 = '0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outs(0);
      check_reset_outs(1);
      @(posedge clk);
      #1;
      rst = 0;
      for (int i = 0; i < 2; i++) begin
         exp_gnt[i].delete(); exp_rsp[i].delete(); glog[i].delete(); model_last[i] = 1;
      end
   endtask

   function automatic int predict(int i, bit va, bit vb);
      if (va && vb) return (i == 0) ? ((model_last[i] == 1) ? 0 : 1) : 0;
      return va ? 0 : 1;
   endfunction

   task automatic wait_ready(int i);
      int n = 0;
      while (!(rdy0[i] || rdy1[i]) && n < 400) begin @(posedge clk); #1; n++; end
      if (n >= 400) expect_eq("ready_timeout", 64'(n), 64'd0);
      v0[i] = 0; v1[i] = 0;
   endtask

   task automatic wait_done(int i, int d0);
      int n = 0;
      while (done_cnt[i] == d0 && n < 2000) begin
         @(posedge clk); #1;
         rr0[i] = 1'($urandom); rr1[i] = 1'($urandom);
         n++;
      end
      if (n >= 2000) expect_eq("resp_timeout", 64'(n), 64'd0);
      rr0[i] = 0; rr1[i] = 0;
   endtask

   task automatic do_op(int i, bit va, bit vb, logic [31:0] xa0, logic [31:0] xb0,
                        logic [31:0] xa1, logic [31:0] xb1);
      int w;
      int d0;
      d0 = done_cnt[i];
      w = predict(i, va, vb);
      exp_gnt[i].push_back(w);
      exp_rsp[i].push_back('{w, (w == 1) ? ref_div(xa1, xb1) : ref_div(xa0, xb0)});
      model_last[i] = w;
      a0[i] = xa0; b0[i] = xb0; a1[i] = xa1; b1[i] = xb1;
      v0[i] = va; v1[i] = vb;
      wait_ready(i);
      wait_done(i, d0);
   endtask

   initial begin : stim
      int          d0;
      int          n;
      bit          va, vb;
      logic [31:0] zexp;
      rst = 1; v0 = '0; v1 = '0; rr0 = '0; rr1 = '0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      for (int i = 0; i < 2; i++) begin done_cnt[i] = 0; last_z[i] = '0; dlat[i] = 3; model_last[i] = 1; end
      do_reset();

      do_op(0, 1, 0, 32'h40C00000, 32'h40000000, 32'h0, 32'h0);
      expect_eq("single_op_z", 64'(last_z[0]), 64'h40400000);
      expect_eq("latency_range", 64'((dcyc[0] != 8'd0) && (dcyc[0] != 8'hFF)), 64'd1);
      do_op(0, 0, 1, 32'h0, 32'h0, 32'h3F800000, 32'h00000000);
      expect_eq("div_by_zero_z", 64'(last_z[0]), 64'h7F800000);

      do_reset();
      for (int k = 0; k < 4; k++) do_op(0, 1, 1, rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp());
      for (int k = 0; k < 4; k++) do_op(1, 1, 1, rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp());
      for (int k = 0; k < 4; k++) begin
         expect_eq($sformatf("tie_rr_%0d", k), 64'(glog[0][k]), 64'(k % 2));
         expect_eq($sformatf("tie_fixed_%0d", k), 64'(glog[1][k]), 64'd0);
      end

      for (int k = 0; k < 24; k++) begin
         va = 1'($urandom); vb = 1'($urandom);
         if (!va && !vb) va = 1;
         dlat[k % 2] = $urandom_range(1, 6);
         do_op(k % 2, va, vb, rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp());
      end
      dlat[0] = 3; dlat[1] = 3;

      // Backpressure: r0 response held 20 cycles while r1 is requesting.
      d0 = done_cnt[0];
      a0[0] = rnd_fp(); b0[0] = rnd_fp();
      zexp = ref_div(a0[0], b0[0]);
      exp_gnt[0].push_back(0); exp_rsp[0].push_back('{0, zexp}); model_last[0] = 0;
      v0[0] = 1; rr0[0] = 0;
      wait_ready(0);
      n = 0;
      while (!rv0[0] && n < 400) begin @(posedge clk); #1; n++; end
      if (n >= 400) expect_eq("bp_resp_timeout", 64'(n), 64'd0);
      a1[0] = rnd_fp(); b1[0] = rnd_fp();
      exp_gnt[0].push_back(1); exp_rsp[0].push_back('{1, ref_div(a1[0], b1[0])}); model_last[0] = 1;
      v1[0] = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         expect_eq("bp_hold", 64'({rv0[0], rdy1[0], rz[0]}), 64'({1'b1, 1'b0, zexp}));
      end
      @(posedge clk); #1;
      rr0[0] = 1;
      n = 0;
      while (done_cnt[0] == d0 && n < 10) begin @(posedge clk); #1; n++; end
      rr0[0] = 0;
      d0 = done_cnt[0];
      wait_ready(0);
      wait_done(0, d0);

      dlat[0] = 300;
      do_op(0, 1, 0, rnd_fp(), rnd_fp(), 32'h0, 32'h0);
      expect_eq("div_cycles_sat", 64'(dcyc[0]), 64'd255);

      // Reset 10 cycles into WAIT_Z: no response may appear, then a clean op follows.
      dlat[0] = 40;
      exp_gnt[0].push_back(0);
      a0[0] = 32'h40400000; b0[0] = 32'h3F800000; v0[0] = 1;
      wait_ready(0);
      n = 0;
      while (!zack[0] && n < 400) begin @(posedge clk); #1; n++; end
      if (n >= 400) expect_eq("wait_z_timeout", 64'(n), 64'd0);
      repeat (9) @(posedge clk);
      do_reset();
      dlat[0] = 3;
      do_op(0, 1, 0, 32'h41200000, 32'h40A00000, 32'h0, 32'h0);
      expect_eq("post_reset_z", 64'(last_z[0]), 64'h40000000);

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_div_arbiter.md
FPU_DIV_ARBITER -- requirements
Module: fpu_div_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin grant; 0 = fixed priority, port 0 always wins.
REQ-002 clk  input  1  clock; all logic on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 r0_valid / r1_valid  input  1 each  requester n has an operation pending.
REQ-005 r0_a, r0_b / r1_a, r1_b  input  32 each  IEEE-754 single-precision dividend and divisor.
REQ-006 r0_ready / r1_ready  output  1 each  one-cycle pulse; the operands of port n were accepted.
REQ-007 r0_resp_valid / r1_resp_valid  output  1 each  the result for port n is valid.
REQ-008 r0_resp_ready / r1_resp_ready  input  1 each  requester n accepts the result.
REQ-009 resp_z  output  32  quotient; shared by both response ports.
REQ-010 div_a, div_b  output  32 each  operands to the shared divider.
REQ-011 div_a_stb, div_b_stb  output  1 each  operand strobes to the divider.
REQ-012 div_a_ack, div_b_ack  input  1 each  operand acks from the divider.
REQ-013 div_z  input  32  divider result.
REQ-014 div_z_stb  input  1  divider result strobe.
REQ-015 div_z_ack  output  1  result ack to the divider.
REQ-016 div_cycles  output  8  latency of the last operation, saturating.

Function
REQ-017 FSM states: IDLE, SEND_A, SEND_B, WAIT_Z, RESP; exactly one operation is in flight at a time.
REQ-018 IDLE with at least one rn_valid: select a winner, register both of its operands, pulse its rn_ready for one cycle, record grant id, go to SEND_A.
REQ-019 RR_EN=1 with both valid: grant the port not granted last; last_grant resets to 1, so port 0 wins the first tie.
REQ-020 A lone valid requester is always granted, regardless of last_grant.
REQ-021 SEND_A: div_a_stb=1 and div_a=registered a; on a cycle with div_a_stb && div_a_ack, drop div_a_stb next cycle and go to SEND_B.
REQ-022 SEND_B: same rule using div_b_stb/div_b_ack; on the handshake, go to WAIT_Z.
REQ-023 WAIT_Z: div_z_ack=1; on div_z_stb && div_z_ack, register div_z, drop div_z_ack next cycle, go to RESP.
REQ-024 Strobes and acks to the divider are driven only from registers; none depends combinationally on a divider input.
REQ-025 RESP: resp_z = registered quotient; the granted port's rn_resp_valid=1 and the other port's stays 0.
REQ-026 RESP: on rn_resp_ready for the granted port, update last_grant, go to IDLE; hold resp_z and resp_valid stable while ready is low, with no limit.
REQ-027 rn_valid is ignored outside IDLE; no operand is accepted while busy.
REQ-028 Requester-side latency: IDLE to SEND_A takes 1 cycle; a new grant is possible the cycle after RESP completes.
REQ-029 Cycle counter: cleared on entry to SEND_A; increments every cycle through SEND_A, SEND_B and WAIT_Z; saturates at 255.
REQ-030 div_cycles loads the counter value when div_z is captured and holds it until the next capture.
REQ-031 Operand values are passed through unmodified; NaN, inf and zero handling belongs to the divider.

Reset
REQ-032 On rst: state=IDLE, last_grant=1, div_cycles=0, and all of these are 0: r*_ready, r*_resp_valid, div_a_stb, div_b_stb, div_z_ack, resp_z, div_a, div_b.
REQ-033 rst in any state, including mid-WAIT_Z, abandons the operation with no response issued; the divider shares the same rst, so both restart together.
REQ-034 rst has priority over every handshake sampled in the same cycle.

Verification
REQ-035 Single op: r0 sends a=0x40C00000, b=0x40000000 -> r0_ready pulses once; r0_resp_valid with resp_z=0x40400000; r1_resp_valid stays 0.
REQ-036 Divide by zero: r1 sends a=0x3F800000, b=0x00000000 -> r1_resp_valid with resp_z=0x7F800000.
REQ-037 Tie after reset: r0 and r1 valid together, RR_EN=1 -> order r0, r1, r0, r1 over 4 ops; with RR_EN=0 -> r0 for all 4.
REQ-038 Backpressure: hold r0_resp_ready low 20 cycles in RESP -> resp_z stable, no new grant, r1_ready stays 0 throughout.
REQ-039 Reset mid-op: assert rst 10 cycles into WAIT_Z -> next cycle all outputs at reset values; a following op 0x41200000/0x40A00000 returns 0x40000000.
REQ-040 Latency check: div_cycles equals the cycle count from SEND_A entry to z capture, measured by the bench; the value is nonzero and not saturated for a normal op.
